zone_alarm_fsm: RTL and testbench

ZONE_ALARM_FSM -- requirements
Module: zone_alarm_fsm

---
 rtl/zone_alarm_pkg.sv | 19 +
 rtl/dwell_counter.sv | 34 +++
 rtl/zone_alarm_fsm.sv | 143 ++++++++++++++
 tb/tb_zone_alarm_fsm.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/zone_alarm_pkg.sv
// Shared types and helpers for the zone alarm controller.
package zone_alarm_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        DISARMED    = 3'd0,
        ARM_PENDING = 3'd1,
        ARMED       = 3'd2,
        TRIGGERED   = 3'd3,
        PANIC       = 3'd4
    } state_e;

    // Bits needed to hold 0..ticks-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned ticks);
        return (ticks <= 1) ? 1 : $clog2(ticks);
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Single dwell counter shared by the exit-delay and alarm-hold states.
module dwell_counter
    import zone_alarm_pkg::*;
#(
    parameter int unsigned ARM_TC  = 50,
    parameter int unsigned HOLD_TC = 100
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic clear,
    input  logic enable,
    input  logic use_hold,
    output logic expired
);

    localparam int unsigned MAX_TC = (ARM_TC > HOLD_TC) ? ARM_TC : HOLD_TC;
    localparam int unsigned CNT_W  = cnt_width(MAX_TC);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] term_c;

    assign term_c  = use_hold ? CNT_W'(HOLD_TC - 1) : CNT_W'(ARM_TC - 1);
    assign expired = enable && (cnt_q == term_c);

    // Wraps on expiry so an unhandled terminal count cannot overflow.
    always_ff @(posedge iCLK) begin
        if (iRST || clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= expired ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/zone_alarm_fsm.sv
// Zone alarm controller: arm/disarm, exit delay, zone trigger and panic.
// Define ZONE_BYPASS_EN to add the zone_bypass input.
module zone_alarm_fsm
    import zone_alarm_pkg::*;
#(
    parameter int unsigned NUM_ZONES        = 3,
    parameter int unsigned ARM_DELAY_TICKS  = 50,
    parameter int unsigned ALARM_HOLD_TICKS = 100
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 panic_key,
    input  logic                 arm_key,
    input  logic [NUM_ZONES-1:0] zone_sensor,
`ifdef ZONE_BYPASS_EN
    input  logic [NUM_ZONES-1:0] zone_bypass,
`endif
    output logic [STATE_W-1:0]   state,
    output logic                 alarm,
    output logic [NUM_ZONES-1:0] zone_latched
);

    state_e               state_q, state_nxt;
    logic                 ret_q, ret_nxt;
    logic [NUM_ZONES-1:0] latch_nxt;
    logic [NUM_ZONES-1:0] active;
    logic                 alarm_nxt;
    logic                 restart;
    logic                 expired;
    logic                 cnt_en;
    logic                 use_hold;

`ifdef ZONE_BYPASS_EN
    assign active = zone_sensor & ~zone_bypass;
`else
    assign active = zone_sensor;
`endif

    assign use_hold = (state_q == TRIGGERED) || (state_q == PANIC);
    assign cnt_en   = use_hold || (state_q == ARM_PENDING);

    dwell_counter #(
        .ARM_TC  (ARM_DELAY_TICKS),
        .HOLD_TC (ALARM_HOLD_TICKS)
    ) u_dwell (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .clear    (restart || (state_nxt != state_q)),
        .enable   (cnt_en),
        .use_hold (use_hold),
        .expired  (expired)
    );

    // State and registered outputs.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q      <= DISARMED;
            ret_q        <= 1'b0;
            alarm        <= 1'b0;
            zone_latched <= '0;
        end else begin
            state_q      <= state_nxt;
            ret_q        <= ret_nxt;
            alarm        <= alarm_nxt;
            zone_latched <= latch_nxt;
        end
    end

    // Next state; panic beats arm, arm beats expiry, expiry beats zones.
    always_comb begin
        state_nxt = state_q;
        ret_nxt   = ret_q;
        latch_nxt = zone_latched;
        restart   = 1'b0;
        case (state_q)
            DISARMED: begin
                if (panic_key) begin
                    state_nxt = PANIC;
                    ret_nxt   = 1'b0;
                end else if (arm_key) begin
                    state_nxt = ARM_PENDING;
                end
            end
            ARM_PENDING: begin
                if (panic_key) begin
                    state_nxt = PANIC;
                    ret_nxt   = 1'b0;
                end else if (arm_key) begin
                    state_nxt = DISARMED;
                end else if (expired) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (panic_key) begin
                    state_nxt = PANIC;
                    ret_nxt   = 1'b1;
                end else if (arm_key) begin
                    state_nxt = DISARMED;
                end else if (|active) begin
                    state_nxt = TRIGGERED;
                    latch_nxt = zone_latched | active;
                end
            end
            TRIGGERED: begin
                latch_nxt = zone_latched | active;
                if (panic_key) begin
                    state_nxt = PANIC;
                    ret_nxt   = 1'b1;
                end else if (arm_key) begin
                    state_nxt = DISARMED;
                end else if (expired) begin
                    if (|active) begin
                        restart = 1'b1;
                    end else begin
                        state_nxt = ARMED;
                    end
                end
            end
            PANIC: begin
                if (panic_key) begin
                    restart = 1'b1;
                end else if (arm_key) begin
                    state_nxt = DISARMED;
                end else if (expired) begin
                    state_nxt = ret_q ? ARMED : DISARMED;
                end
            end
            default: state_nxt = DISARMED;
        endcase
        if (state_nxt == DISARMED) begin
            latch_nxt = '0;
        end
    end

    // Output decode from the upcoming state.
    always_comb begin
        alarm_nxt = (state_nxt == TRIGGERED) || (state_nxt == PANIC);
    end

    assign state = state_q;

endmodule

// File: tb/tb_zone_alarm_fsm.sv
// Table-driven bench for zone_alarm_fsm with a per-cycle scoreboard.
module tb_zone_alarm_fsm;

    localparam logic [2:0] S_DIS = 3'd0;
    localparam logic [2:0] S_AP  = 3'd1;
    localparam logic [2:0] S_ARM = 3'd2;
    localparam logic [2:0] S_TRG = 3'd3;
    localparam logic [2:0] S_PAN = 3'd4;

    typedef struct {
        logic       rst;
        logic       pk;
        logic       ak;
        logic [3:0] zs;
        logic [3:0] zb;
        int         n;
        logic [2:0] st;
        logic       al;
        logic [3:0] zl;
    } vec_t;

    typedef struct {
        logic [2:0] st;
        logic       al;
        logic [3:0] zl;
        int         idx;
    } exp_t;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic       panic_key = 1'b0;
    logic       arm_key = 1'b0;
    logic [3:0] zone_sensor = '0;
    logic [3:0] zone_bypass = '0;
    logic [2:0] state;
    logic       alarm;
    logic [3:0] zone_latched;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 iCLK = ~iCLK;

    zone_alarm_fsm #(
        .NUM_ZONES        (4),
        .ARM_DELAY_TICKS  (5),
        .ALARM_HOLD_TICKS (10)
    ) dut (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .panic_key    (panic_key),
        .arm_key      (arm_key),
        .zone_sensor  (zone_sensor),
`ifdef ZONE_BYPASS_EN
        .zone_bypass  (zone_bypass),
`endif
        .state        (state),
        .alarm        (alarm),
        .zone_latched (zone_latched)
    );

    task automatic add(input logic rst, input logic pk, input logic ak,
                       input logic [3:0] zs, input logic [3:0] zb, input int n,
                       input logic [2:0] st, input logic al, input logic [3:0] zl);
        vec_t v;
        v.rst = rst; v.pk = pk; v.ak = ak; v.zs = zs; v.zb = zb;
        v.n = n; v.st = st; v.al = al; v.zl = zl;
        vecs.push_back(v);
    endtask

    task automatic check_now(input string tag, input logic [2:0] st,
                             input logic al, input logic [3:0] zl);
        n_vec++;
        if (state !== st || alarm !== al || zone_latched !== zl) begin
            n_err++;
            $display("FAIL %s: got state=%0d alarm=%b latched=%b, want state=%0d alarm=%b latched=%b",
                     tag, state, alarm, zone_latched, st, al, zl);
        end
    endtask

    initial begin
        // directed preamble: reset state and exit-delay expiry
        @(negedge iCLK);
        iRST = 1'b1; panic_key = 1'b1; arm_key = 1'b1; zone_sensor = 4'b1111;
        @(posedge iCLK);
        #1;
        check_now("reset", S_DIS, 1'b0, 4'b0000);
        @(negedge iCLK);
        iRST = 1'b0; panic_key = 1'b0; arm_key = 1'b1; zone_sensor = 4'b0000;
        @(posedge iCLK);
        #1;
        check_now("arm", S_AP, 1'b0, 4'b0000);
        @(negedge iCLK);
        arm_key = 1'b0;
        repeat (4) @(posedge iCLK);
        #1;
        check_now("pending", S_AP, 1'b0, 4'b0000);
        @(posedge iCLK);
        #1;
        check_now("expired", S_ARM, 1'b0, 4'b0000);

        // reset, arm, exit delay of exactly 5 cycles
        add(1, 0, 0, 4'b0000, 4'b0000, 2, S_DIS, 0, 4'b0000);
        add(0, 0, 0, 4'b1111, 4'b0000, 3, S_DIS, 0, 4'b0000);
        add(0, 0, 1, 4'b0000, 4'b0000, 1, S_AP,  0, 4'b0000);
        add(0, 0, 0, 4'b1111, 4'b0000, 4, S_AP,  0, 4'b0000);
        add(0, 0, 0, 4'b0000, 4'b0000, 1, S_ARM, 0, 4'b0000);
        add(0, 0, 0, 4'b0000, 4'b0000, 3, S_ARM, 0, 4'b0000);
        // single zone trip, 10-cycle hold, latch stays
        add(0, 0, 0, 4'b0100, 4'b0000, 1, S_TRG, 1, 4'b0100);
        add(0, 0, 0, 4'b0000, 4'b0000, 9, S_TRG, 1, 4'b0100);
        add(0, 0, 0, 4'b0000, 4'b0000, 1, S_ARM, 0, 4'b0100);
        // zone 1 held through expiry restarts the hold
        add(0, 0, 0, 4'b0100, 4'b0000, 1, S_TRG, 1, 4'b0100);
        add(0, 0, 0, 4'b0010, 4'b0000, 9, S_TRG, 1, 4'b0110);
        add(0, 0, 0, 4'b0010, 4'b0000, 1, S_TRG, 1, 4'b0110);
        add(0, 0, 0, 4'b0000, 4'b0000, 9, S_TRG, 1, 4'b0110);
        add(0, 0, 0, 4'b0000, 4'b0000, 1, S_ARM, 0, 4'b0110);
        add(0, 0, 1, 4'b0000, 4'b0000, 1, S_DIS, 0, 4'b0000);
        // panic from DISARMED returns to DISARMED
        add(0, 1, 0, 4'b0000, 4'b0000, 1, S_PAN, 1, 4'b0000);
        add(0, 0, 0, 4'b1000, 4'b0000, 9, S_PAN, 1, 4'b0000);
        add(0, 0, 0, 4'b0000, 4'b0000, 1, S_DIS, 0, 4'b0000);
        // arm_key held toggles every cycle
        add(0, 0, 1, 4'b0000, 4'b0000, 1, S_AP,  0, 4'b0000);
        add(0, 0, 1, 4'b0000, 4'b0000, 1, S_DIS, 0, 4'b0000);
        // panic from ARMED returns to ARMED
        add(0, 0, 1, 4'b0000, 4'b0000, 1, S_AP,  0, 4'b0000);
        add(0, 0, 0, 4'b0000, 4'b0000, 4, S_AP,  0, 4'b0000);
        add(0, 0, 0, 4'b0000, 4'b0000, 1, S_ARM, 0, 4'b0000);
        add(0, 1, 0, 4'b0000, 4'b0000, 1, S_PAN, 1, 4'b0000);
        add(0, 0, 0, 4'b0000, 4'b0000, 9, S_PAN, 1, 4'b0000);
        add(0, 0, 0, 4'b0000, 4'b0000, 1, S_ARM, 0, 4'b0000);
        // panic held restarts the hold
        add(0, 1, 0, 4'b0000, 4'b0000, 3, S_PAN, 1, 4'b0000);
        add(0, 0, 0, 4'b0000, 4'b0000, 9, S_PAN, 1, 4'b0000);
        add(0, 0, 0, 4'b0000, 4'b0000, 1, S_ARM, 0, 4'b0000);
        // panic beats arm; arm in PANIC disarms
        add(0, 1, 1, 4'b0000, 4'b0000, 1, S_PAN, 1, 4'b0000);
        add(0, 0, 1, 4'b0000, 4'b0000, 1, S_DIS, 0, 4'b0000);
        // reset mid exit delay overrides keys
        add(0, 0, 1, 4'b0000, 4'b0000, 1, S_AP,  0, 4'b0000);
        add(0, 0, 0, 4'b0000, 4'b0000, 2, S_AP,  0, 4'b0000);
        add(1, 1, 1, 4'b1111, 4'b0000, 1, S_DIS, 0, 4'b0000);
        add(0, 0, 0, 4'b1111, 4'b0000, 6, S_DIS, 0, 4'b0000);
        // bypassed zone in ARMED
        add(0, 0, 1, 4'b0000, 4'b0001, 1, S_AP,  0, 4'b0000);
        add(0, 0, 0, 4'b0000, 4'b0001, 4, S_AP,  0, 4'b0000);
        add(0, 0, 0, 4'b0000, 4'b0001, 1, S_ARM, 0, 4'b0000);
`ifdef ZONE_BYPASS_EN
        add(0, 0, 0, 4'b0001, 4'b0001, 2, S_ARM, 0, 4'b0000);
`else
        add(0, 0, 0, 4'b0001, 4'b0001, 2, S_TRG, 1, 4'b0001);
`endif
        add(0, 0, 1, 4'b0000, 4'b0000, 1, S_DIS, 0, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            for (int r = 0; r < vecs[i].n; r++) begin
                exp_t e;
                exp_t got;
                @(negedge iCLK);
                iRST        = vecs[i].rst;
                panic_key   = vecs[i].pk;
                arm_key     = vecs[i].ak;
                zone_sensor = vecs[i].zs;
                zone_bypass = vecs[i].zb;
                e.st = vecs[i].st; e.al = vecs[i].al; e.zl = vecs[i].zl; e.idx = i;
                sb.push_back(e);
                @(posedge iCLK);
                #1;
                got = sb.pop_front();
                n_vec++;
                if (state !== got.st || alarm !== got.al || zone_latched !== got.zl) begin
                    n_err++;
                    $display("FAIL vec%0d cyc%0d: got state=%0d alarm=%b latched=%b, want state=%0d alarm=%b latched=%b",
                             got.idx, r, state, alarm, zone_latched, got.st, got.al, got.zl);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
